// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32 load/store unit.
package lsu_pkg;

   localparam int unsigned LSU_ADDR_W = 6;
   localparam int unsigned LSU_XLEN   = 32;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WRITE  = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_e;

   // RV32I funct3 access-size codes
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // Cycles from acceptance edge to the rsp_valid cycle
   localparam int unsigned LAT_LOAD    = 2;
   localparam int unsigned LAT_SW      = 2;
   localparam int unsigned LAT_SUBWORD = 3;
   localparam int unsigned LAT_ERR     = 1;

   // Latched request control fields
   typedef struct packed {
      logic       write;
      logic [2:0] funct3;
      logic [1:0] offset;
   } lsu_req_t;

   // Illegal funct3 or misaligned offset for the access size
   function automatic logic lsu_req_bad(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
      logic illegal;
      logic misaligned;
      if (write) illegal = (funct3 > F3_W);
      else       illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && offset[0]) ||
                   ((funct3 == F3_W) && (offset != 2'b00));
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extraction/extension and sub-word store merge.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = LSU_XLEN
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      offset_i,
   input  logic [XLEN-1:0] word_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] load_data_c_o,
   output logic [XLEN-1:0] merge_data_c_o
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   // Select the addressed byte and halfword from the memory word
   always_comb begin
      byte_c = word_i[{offset_i, 3'b000} +: 8];
      half_c = word_i[{offset_i[1], 4'b0000} +: 16];
   end

   // Sign- or zero-extend the selected lane
   always_comb begin
      load_data_c_o = '0;
      case (funct3_i)
         F3_B:    load_data_c_o = {{(XLEN-8){byte_c[7]}}, byte_c};
         F3_BU:   load_data_c_o = {{(XLEN-8){1'b0}}, byte_c};
         F3_H:    load_data_c_o = {{(XLEN-16){half_c[15]}}, half_c};
         F3_HU:   load_data_c_o = {{(XLEN-16){1'b0}}, half_c};
         F3_W:    load_data_c_o = word_i;
         default: load_data_c_o = '0;
      endcase
   end

   // Substitute the store lane(s) into the old word
   always_comb begin
      merge_data_c_o = word_i;
      case (funct3_i)
         F3_B:    merge_data_c_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
         F3_H:    merge_data_c_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: merge_data_c_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/rv32_lsu.sv
// RV32 MEM-stage load/store unit for a word-addressed data memory without
// byte enables; SB/SH are done as read-modify-write.
// Optional: define LSU_BOUNDS_CHECK_EN to flag addresses above the memory
// range as errors instead of wrapping.
module rv32_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = LSU_ADDR_W,
   parameter int unsigned XLEN   = LSU_XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              req_ready,
   output logic              stall,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   lsu_state_e        state_q, state_d;
   lsu_req_t          req_q, req_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   // Doubles as the merge buffer for SB/SH
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

   logic [XLEN-1:0]   load_data_c;
   logic [XLEN-1:0]   merge_data_c;
   logic              req_bad_c;

   // Request classification at acceptance
`ifdef LSU_BOUNDS_CHECK_EN
   assign req_bad_c = lsu_req_bad(req_write, req_funct3, req_addr[1:0]) ||
                      (|req_addr[XLEN-1:ADDR_W+2]);
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W+2];
   assign req_bad_c      = lsu_req_bad(req_write, req_funct3, req_addr[1:0]);
`endif

   lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .funct3_i       (req_q.funct3),
      .offset_i       (req_q.offset),
      .word_i         (mem_rdata),
      .wdata_i        (wdata_q),
      .load_data_c_o  (load_data_c),
      .merge_data_c_o (merge_data_c)
   );

   // State, request and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         err_q       <= 1'b0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         err_q       <= err_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next-state, datapath updates and next-cycle output decode
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      err_d       = err_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               req_d.write  = req_write;
               req_d.funct3 = req_funct3;
               req_d.offset = req_addr[1:0];
               wdata_d      = req_wdata;
               mem_addr_d   = req_addr[ADDR_W+1:2];
               rsp_rdata_d  = '0;
               mem_wdata_d  = '0;
               err_d        = req_bad_c;
               if (req_bad_c) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_ACCESS;
                  if (req_write && (req_funct3 == F3_W)) mem_wdata_d = req_wdata;
               end
            end
         end
         ST_ACCESS: begin
            if (!req_q.write) begin
               rsp_rdata_d = load_data_c;
               state_d     = ST_RESP;
            end else if (req_q.funct3 == F3_W) begin
               state_d = ST_RESP;
            end else begin
               mem_wdata_d = merge_data_c;
               state_d     = ST_WRITE;
            end
         end
         ST_WRITE: state_d = ST_RESP;
         ST_RESP: begin
            mem_wdata_d = '0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      rsp_err_d   = (state_d == ST_RESP) && err_d;
      mem_read_d  = (state_d == ST_ACCESS) && !(req_d.write && (req_d.funct3 == F3_W));
      mem_write_d = ((state_d == ST_ACCESS) && req_d.write && (req_d.funct3 == F3_W)) ||
                    (state_d == ST_WRITE);
   end

   // Freeze the pipeline from request presentation until the response cycle
   assign stall = ((state_q == ST_IDLE) && req_valid) ||
                  (state_q == ST_ACCESS) || (state_q == ST_WRITE);

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rv32_lsu.sv
// Bench for rv32_lsu: word memory model plus a byte-array reference model.
module tb_rv32_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] tb_mem  [64];
   logic [7:0]  ref_mem [256];

   // Observations from the last do_access
   logic [31:0] obs_rdata;
   logic        obs_err;
   int          obs_lat;
   int          obs_stalls;
   int          obs_reads;
   int          obs_writes;
   int          obs_both;
   int          obs_read_cyc;
   int          obs_write_cyc;
   int          obs_waits;
   logic [31:0] obs_wdata;
   logic        obs_ok;

   rv32_lsu dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (mem_write) tb_mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem_read ? tb_mem[mem_addr] : 32'h0;

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
      longint v;
      v = 0;
      case (f3)
         3'd0: begin v = longint'(ref_mem[a]); if (v >= 128) v = v - 256; end
         3'd4: v = longint'(ref_mem[a]);
         3'd1: begin
            v = longint'(ref_mem[a]) + 256 * longint'(ref_mem[a+1]);
            if (v >= 32768) v = v - 65536;
         end
         3'd5: v = longint'(ref_mem[a]) + 256 * longint'(ref_mem[a+1]);
         3'd2: v = longint'(ref_mem[a]) + 256 * longint'(ref_mem[a+1]) +
                   65536 * longint'(ref_mem[a+2]) + 16777216 * longint'(ref_mem[a+3]);
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic int ref_size(input logic [2:0] f3);
      if (f3 == 3'd2) return 4;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 1;
   endfunction

   function automatic logic ref_bad(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
      logic legal;
      int   a;
      a = int'(addr[7:0]);
      if (wr) legal = (f3 <= 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef LSU_BOUNDS_CHECK_EN
      if (addr > 32'd255) return 1'b1;
`endif
      return !legal || ((a % ref_size(f3)) != 0);
   endfunction

   task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
      for (int i = 0; i < ref_size(f3); i++) ref_mem[a+i] = 8'(wd >> (8 * i));
   endtask

   task automatic preload(input int w, input logic [31:0] val);
      tb_mem[w] = val;
      for (int i = 0; i < 4; i++) ref_mem[4*w+i] = 8'(val >> (8 * i));
   endtask

   function automatic int ref_lat(input logic wr, input logic [2:0] f3, input logic er);
      if (er) return 1;
      if (wr && f3 != 3'd2) return 3;
      return 2;
   endfunction

   // ---------------- driver ----------------
   // Present one request from just after a negedge; collect response timing.
   task automatic do_access(input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
      logic rdy;
      logic st_acc;
      rdy = 1'b0;
      st_acc = 1'b0;
      obs_rdata = 32'h0; obs_err = 1'b0; obs_lat = 0; obs_stalls = 0;
      obs_reads = 0; obs_writes = 0; obs_both = 0; obs_read_cyc = 0;
      obs_write_cyc = 0; obs_waits = 0; obs_wdata = 32'h0; obs_ok = 1'b0;
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      for (int i = 0; i < 8; i++) begin
         #1;
         rdy    = req_ready;
         st_acc = stall;
         @(posedge clk);
         if (rdy) break;
         obs_waits++;
         @(negedge clk);
      end
      if (!rdy) begin
         req_valid = 1'b0;
         return;
      end
      if (st_acc) obs_stalls++;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid  = 1'b0;
            req_write  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
         end
         #1;
         if (mem_read) begin obs_reads++; obs_read_cyc = c; end
         if (mem_write) begin obs_writes++; obs_write_cyc = c; obs_wdata = mem_wdata; end
         if (mem_read && mem_write) obs_both++;
         if (stall) obs_stalls++;
         if (rsp_valid) begin
            obs_rdata = rsp_rdata;
            obs_err   = rsp_err;
            obs_lat   = c;
            obs_ok    = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         bad++; $display("FAIL reset_mem_en got=%b%b want=00", mem_read, mem_write); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [3];
      logic [31:0] adr [3];
      logic [31:0] exp [3];
      f3s[0] = 3'd0; adr[0] = 32'h4; exp[0] = 32'hFFFF_FFF9;
      f3s[1] = 3'd4; adr[1] = 32'h4; exp[1] = 32'h0000_00F9;
      f3s[2] = 3'd1; adr[2] = 32'h6; exp[2] = 32'hFFFF_8000;
      preload(1, 32'h8000_00F9);
      for (int i = 0; i < 3; i++) begin
         do_access(1'b0, f3s[i], adr[i], 32'h0);
         total++; if (!obs_ok || obs_rdata !== exp[i] || obs_err !== 1'b0) begin
            bad++; $display("FAIL load_%0d rdata=%h err=%b want rdata=%h err=0", i, obs_rdata, obs_err, exp[i]); end
         total++; if (obs_lat != 2) begin
            bad++; $display("FAIL load_%0d_latency got=%0d want=2", i, obs_lat); end
      end
   endtask

   task automatic test_sb_sequence();
      preload(2, 32'h1122_3344);
      do_access(1'b1, 3'd0, 32'h9, 32'h0000_00AB);
      total++; if (obs_reads != 1 || obs_read_cyc != 1) begin
         bad++; $display("FAIL sb_read reads=%0d cyc=%0d want 1 at 1", obs_reads, obs_read_cyc); end
      total++; if (obs_writes != 1 || obs_write_cyc != 2 || obs_wdata !== 32'h1122_AB44) begin
         bad++; $display("FAIL sb_write writes=%0d cyc=%0d data=%h want 1 at 2 data=1122ab44",
                         obs_writes, obs_write_cyc, obs_wdata); end
      total++; if (!obs_ok || obs_lat != 3 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
         bad++; $display("FAIL sb_resp lat=%0d err=%b rdata=%h want 3 0 0", obs_lat, obs_err, obs_rdata); end
      total++; if (obs_stalls != 3) begin
         bad++; $display("FAIL sb_stall got=%0d want=3", obs_stalls); end
      ref_store(3'd0, 9, 32'h0000_00AB);
      total++; if (tb_mem[2] !== 32'h1122_AB44) begin
         bad++; $display("FAIL sb_memword got=%h want=1122ab44", tb_mem[2]); end
   endtask

   task automatic test_errors();
      logic        wrs [4];
      logic [2:0]  f3s [4];
      logic [31:0] adr [4];
      wrs[0] = 1'b0; f3s[0] = 3'd2; adr[0] = 32'h6;
      wrs[1] = 1'b1; f3s[1] = 3'd1; adr[1] = 32'h3;
      wrs[2] = 1'b0; f3s[2] = 3'd3; adr[2] = 32'h8;
      wrs[3] = 1'b1; f3s[3] = 3'd4; adr[3] = 32'h8;
      for (int i = 0; i < 4; i++) begin
         do_access(wrs[i], f3s[i], adr[i], 32'hFFFF_FFFF);
         total++; if (!obs_ok || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat != 1) begin
            bad++; $display("FAIL err_%0d err=%b rdata=%h lat=%0d want 1 0 1", i, obs_err, obs_rdata, obs_lat); end
         total++; if (obs_reads != 0 || obs_writes != 0) begin
            bad++; $display("FAIL err_%0d_mem reads=%0d writes=%0d want 0 0", i, obs_reads, obs_writes); end
      end
   endtask

   task automatic test_back_to_back();
      do_access(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
      total++; if (!obs_ok || obs_lat != 2 || obs_err !== 1'b0) begin
         bad++; $display("FAIL b2b_sw lat=%0d err=%b want 2 0", obs_lat, obs_err); end
      ref_store(3'd2, 16, 32'hDEAD_BEEF);
      do_access(1'b0, 3'd2, 32'h10, 32'h0);
      total++; if (obs_waits != 1) begin
         bad++; $display("FAIL b2b_accept waits=%0d want=1", obs_waits); end
      total++; if (!obs_ok || obs_rdata !== 32'hDEAD_BEEF || obs_lat != 2) begin
         bad++; $display("FAIL b2b_lw rdata=%h lat=%0d want deadbeef 2", obs_rdata, obs_lat); end
   endtask

   task automatic test_reset_in_write();
      preload(8, 32'hCAFE_BABE);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h22; req_wdata = 32'h0000_1234;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rstw_access mem_read=%b want=1", mem_read); end
      @(negedge clk);
      #1;
      total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstw_write mem_write=%b want=1", mem_write); end
      rst = 1'b0;
      #1;
      total++; if (mem_write !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL rstw_async mem_write=%b req_ready=%b want 0 1", mem_write, req_ready); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (tb_mem[8] !== ref_load(3'd2, 32) || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++; $display("FAIL rstw_after mem=%h ready=%b valid=%b want cafebabe 1 0", tb_mem[8], req_ready, rsp_valid); end
      @(negedge clk);
      do_access(1'b0, 3'd2, 32'h20, 32'h0);
      total++; if (!obs_ok || obs_rdata !== 32'hCAFE_BABE) begin
         bad++; $display("FAIL rstw_reload rdata=%h want=cafebabe", obs_rdata); end
   endtask

   task automatic test_bounds();
      preload(0, 32'h0BAD_F00D);
      do_access(1'b0, 3'd2, 32'h100, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
      total++; if (!obs_ok || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat != 1 || obs_reads != 0) begin
         bad++; $display("FAIL bounds err=%b rdata=%h lat=%0d reads=%0d want 1 0 1 0", obs_err, obs_rdata, obs_lat, obs_reads); end
`else
      total++; if (!obs_ok || obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_F00D || obs_lat != 2) begin
         bad++; $display("FAIL bounds err=%b rdata=%h lat=%0d want 0 0badf00d 2", obs_err, obs_rdata, obs_lat); end
`endif
   endtask

   task automatic test_random();
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        eb;
      logic [31:0] er;
      int          a;
      int          sz;
      for (int n = 0; n < 60; n++) begin
         wr = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
               f3 = 3'($urandom_range(0, 4));
               if (f3 == 3'd3) f3 = 3'd5;
            end
         end
         sz = ref_size(f3);
         a  = $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0) a = a - (a % sz);
         addr = 32'(a);
         if ($urandom_range(0, 5) == 0) addr = addr | ({$urandom} & 32'hFFFF_FF00);
         wd = $urandom;
         eb = ref_bad(wr, f3, addr);
         er = (eb || wr) ? 32'h0 : ref_load(f3, a);
         do_access(wr, f3, addr, wd);
         total++; if (!obs_ok || obs_err !== eb || obs_rdata !== er) begin
            bad++; $display("FAIL rand_%0d wr=%b f3=%0d addr=%h rdata=%h err=%b want %h %b",
                            n, wr, f3, addr, obs_rdata, obs_err, er, eb); end
         total++; if (obs_lat != ref_lat(wr, f3, eb) || obs_both != 0) begin
            bad++; $display("FAIL rand_%0d_timing lat=%0d both=%0d want %0d 0", n, obs_lat, obs_both, ref_lat(wr, f3, eb)); end
         if (wr && !eb) begin
            ref_store(f3, a, wd);
            total++; if (tb_mem[a/4] !== ref_load(3'd2, (a/4)*4)) begin
               bad++; $display("FAIL rand_%0d_mem word=%0d got=%h want=%h", n, a/4, tb_mem[a/4], ref_load(3'd2, (a/4)*4)); end
         end
      end
   endtask

   initial begin
      for (int w = 0; w < 64; w++) preload(w, $urandom);
      test_reset();
      test_loads();
      test_sb_sequence();
      test_errors();
      test_back_to_back();
      test_reset_in_write();
      test_bounds();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule
